// File: rtl/bn128_pkg.sv
// Shared bn128 field/record types and multiexp ingress constants.
package bn128_pkg;
  localparam int FE_BITS = 256;
  typedef logic [FE_BITS-1:0] fe_t;
  typedef struct packed { fe_t k; fe_t y; fe_t x; } mexp_rec_t;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} ingress_state_t;
  localparam logic [7:0] MEXP_OP_LOAD = 8'h01;
endpackage

// File: rtl/if_axi_stream.sv
// Minimal packet stream: val/rdy handshake with start/end-of-packet flags.
interface if_axi_stream #(parameter int DAT_BYTS = 32) ();
  logic                  val;
  logic                  rdy;
  logic                  sop;
  logic                  eop;
  logic [DAT_BYTS*8-1:0] dat;
  modport sink   (input val, dat, sop, eop, output rdy);
  modport source (output val, dat, sop, eop, input rdy);
endinterface

// File: rtl/multiexp_ingress_rr.sv
// Round-robin core pointer with one-hot decode; points at the core the next record goes to.
module multiexp_ingress_rr #(
  parameter int NUM_CORES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 advance,
  input  logic                 clear,
  output logic [NUM_CORES-1:0] onehot
);
  localparam int PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  logic [PW-1:0] ptr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        ptr <= '0;
    else if (clear)   ptr <= '0;
    else if (advance) ptr <= (ptr == PW'(NUM_CORES-1)) ? '0 : ptr + 1'b1;
  end

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_dec
    assign onehot[c] = (ptr == PW'(c));
  end
endmodule

// File: rtl/multiexp_ingress.sv
// Host-stream receiver: validates the LOAD header, assembles (x,y,k) records and
// deals them round-robin to the core array through a single output register.
module multiexp_ingress
  import bn128_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int DAT_BITS  = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  if_axi_stream.sink            rx_if,
  output logic [3*DAT_BITS-1:0] o_rec_dat,
  output logic [NUM_CORES-1:0]  o_rec_val,
  input  logic [NUM_CORES-1:0]  i_rec_rdy,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_rec_cnt
);
  ingress_state_t        state, nxt_state;
  logic [1:0]            beat_idx;
  logic [DAT_BITS-1:0]   x_q, y_q;
  logic [31:0]           n_q, asm_cnt;
  logic                  rdy_en, out_last, out_stale;
  logic                  hs, out_full, acc, last_rec;
  logic                  hdr_ok, err_set, load_out, zero_done;
  logic [NUM_CORES-1:0]  rr_onehot;
  logic [7:0]            opcode;
  logic [31:0]           hdr_n;

  assign hs       = |(o_rec_val & i_rec_rdy);
  assign out_full = |o_rec_val;
  assign opcode   = rx_if.dat[7:0];
  assign hdr_n    = rx_if.dat[39:8];
  assign last_rec = (asm_cnt == n_q - 32'd1);
  // k beat may land in the same cycle the output register drains
  assign rx_if.rdy = rdy_en && !(state == LOAD && beat_idx == 2'd2 && out_full && !hs);
  assign acc       = rx_if.val && rx_if.rdy;
  assign o_busy    = (state != IDLE) || (out_full && out_last);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= nxt_state;
  end

  always_comb begin
    nxt_state = state;
    hdr_ok    = 1'b0;
    err_set   = 1'b0;
    load_out  = 1'b0;
    zero_done = 1'b0;
    case (state)
      IDLE: if (acc && rx_if.sop) begin
        if (opcode != MEXP_OP_LOAD) begin
          err_set = 1'b1;
          if (!rx_if.eop) nxt_state = DRAIN;
        end else if (hdr_n == 32'd0) begin
          if (rx_if.eop) begin
            hdr_ok    = 1'b1;
            zero_done = 1'b1;
          end else begin
            err_set   = 1'b1;
            nxt_state = DRAIN;
          end
        end else if (rx_if.eop) begin
          err_set = 1'b1;
        end else begin
          hdr_ok    = 1'b1;
          nxt_state = LOAD;
        end
      end
      LOAD: if (acc) begin
        if (beat_idx != 2'd2) begin
          if (rx_if.eop) begin
            err_set   = 1'b1;
            nxt_state = IDLE;
          end
        end else if (last_rec && rx_if.eop) begin
          load_out  = 1'b1;
          nxt_state = IDLE;
        end else if (last_rec) begin
          err_set   = 1'b1;
          nxt_state = DRAIN;
        end else if (rx_if.eop) begin
          err_set   = 1'b1;
          nxt_state = IDLE;
        end else begin
          load_out  = 1'b1;
        end
      end
      DRAIN: if (acc && rx_if.eop) nxt_state = IDLE;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdy_en    <= 1'b0;
      beat_idx  <= '0;
      x_q       <= '0;
      y_q       <= '0;
      n_q       <= '0;
      asm_cnt   <= '0;
      out_last  <= 1'b0;
      out_stale <= 1'b0;
      o_rec_dat <= '0;
      o_rec_val <= '0;
      o_done    <= 1'b0;
      o_err     <= 1'b0;
      o_rec_cnt <= '0;
    end else begin
      rdy_en <= 1'b1;
      o_done <= zero_done || (hs && out_last);
      if (err_set) o_err <= 1'b1;
      if (hdr_ok) begin
        n_q      <= hdr_n;
        asm_cnt  <= '0;
        beat_idx <= '0;
      end
      if (state == LOAD && acc) begin
        if (beat_idx == 2'd0) x_q <= rx_if.dat;
        if (beat_idx == 2'd1) y_q <= rx_if.dat;
        beat_idx <= (beat_idx == 2'd2 || rx_if.eop) ? 2'd0 : beat_idx + 2'd1;
        if (load_out) asm_cnt <= asm_cnt + 32'd1;
      end
      if (load_out) begin
        o_rec_dat <= {rx_if.dat, y_q, x_q};
        o_rec_val <= rr_onehot;
        out_last  <= last_rec;
        out_stale <= 1'b0;
      end else if (hs) begin
        o_rec_val <= '0;
      end
      // a record still pending from the previous packet must not count toward the new one
      if (hdr_ok) begin
        o_rec_cnt <= '0;
        out_stale <= out_full && !hs;
      end else if (hs && !out_stale) begin
        o_rec_cnt <= o_rec_cnt + 32'd1;
      end
    end
  end

  multiexp_ingress_rr #(.NUM_CORES(NUM_CORES)) u_rr (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .advance (load_out),
    .clear   (hdr_ok),
    .onehot  (rr_onehot)
  );
endmodule

// File: tb/tb_multiexp_ingress.sv
// Directed bench for multiexp_ingress: header table plus packet sequences.
module tb_multiexp_ingress;
  localparam int NC = 4;
  localparam int DB = 256;
  localparam int RB = 3 * DB;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [RB-1:0] o_rec_dat;
  logic [NC-1:0] o_rec_val;
  logic [NC-1:0] i_rec_rdy;
  logic          o_busy, o_done, o_err;
  logic [31:0]   o_rec_cnt;

  always #5 i_clk = ~i_clk;

  if_axi_stream #(.DAT_BYTS(DB/8)) rx_if ();

  multiexp_ingress #(.NUM_CORES(NC), .DAT_BITS(DB)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .rx_if     (rx_if),
    .o_rec_dat (o_rec_dat),
    .o_rec_val (o_rec_val),
    .i_rec_rdy (i_rec_rdy),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_err     (o_err),
    .o_rec_cnt (o_rec_cnt)
  );

  int checks = 0;
  int failures = 0;

  // monitor samples mid-low-phase, after the bench has driven its inputs
  int            n_done = 0;
  int            rdy_low = 0;
  int            log_core[$];
  logic [RB-1:0] log_dat[$];

  always begin
    @(negedge i_clk);
    #2;
    if (o_done) n_done++;
    if (!rx_if.rdy && !i_rst) rdy_low++;
    for (int c = 0; c < NC; c++)
      if (o_rec_val[c] && i_rec_rdy[c]) begin
        log_core.push_back(c);
        log_dat.push_back(o_rec_dat);
      end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rec(input string nm, input logic [RB-1:0] act, input logic [RB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DB-1:0] word(input int p, input int r, input int j);
    return {32'(p), 184'h0, 8'(j), 32'(r)};
  endfunction

  function automatic logic [RB-1:0] rec(input int p, input int r);
    return {word(p, r, 2), word(p, r, 1), word(p, r, 0)};
  endfunction

  // called at a negedge; returns at the negedge following acceptance
  task automatic beat(input logic [DB-1:0] d, input logic s, input logic e);
    int t = 0;
    rx_if.val = 1'b1;
    rx_if.dat = d;
    rx_if.sop = s;
    rx_if.eop = e;
    forever begin
      #1;
      if (rx_if.rdy) begin
        @(negedge i_clk);
        break;
      end
      @(negedge i_clk);
      t++;
      if (t > 200) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout actual=%0d required=accept", t);
        break;
      end
    end
    rx_if.val = 1'b0;
    rx_if.sop = 1'b0;
    rx_if.eop = 1'b0;
  endtask

  task automatic hdr(input logic [7:0] op, input logic [31:0] n, input logic e,
                     input logic [DB-41:0] junk);
    beat({junk, n, op}, 1'b1, e);
  endtask

  // send nbeats data beats of packet p with eop on beat eop_at
  task automatic data_beats(input int p, input int nbeats, input int eop_at);
    for (int b = 1; b <= nbeats; b++)
      beat(word(p, (b-1)/3, (b-1)%3), 1'b0, b == eop_at);
  endtask

  task automatic chk_recs(input string nm, input int first, input int n, input int p);
    for (int r = 0; r < n; r++) begin
      if (first + r < log_core.size()) begin
        chk({nm, "_core"}, 64'(log_core[first+r]), 64'(r % NC));
        chk_rec({nm, "_dat"}, log_dat[first+r], rec(p, r));
      end else begin
        chk({nm, "_missing"}, 64'(log_core.size()), 64'(first + r + 1));
      end
    end
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  typedef struct {
    logic [7:0]    op;
    logic [31:0]   n;
    logic          eop;
    logic [DB-41:0] junk;
    logic          exp_err;
    int            exp_done;
    logic          exp_busy;
  } hv_t;

  hv_t tbl[7];
  int  d0, l0, r0;

  initial begin
    tbl[0] = '{8'h01, 32'd0, 1'b1, '0, 1'b0, 1, 1'b0};
    tbl[1] = '{8'h01, 32'd0, 1'b0, '0, 1'b1, 0, 1'b1};
    tbl[2] = '{8'h01, 32'd5, 1'b1, '0, 1'b1, 0, 1'b0};
    tbl[3] = '{8'h07, 32'd0, 1'b1, '0, 1'b1, 0, 1'b0};
    tbl[4] = '{8'h01, 32'd0, 1'b1, '1, 1'b0, 1, 1'b0};
    tbl[5] = '{8'h01, 32'd2, 1'b0, '0, 1'b0, 0, 1'b1};
    tbl[6] = '{8'hFF, 32'd3, 1'b0, '0, 1'b1, 0, 1'b1};

    rx_if.val = 1'b0;
    rx_if.sop = 1'b0;
    rx_if.eop = 1'b0;
    rx_if.dat = '0;
    i_rec_rdy = '1;

    // reset state
    @(negedge i_clk);
    #1;
    chk("rst_rdy", 64'(rx_if.rdy), 0);
    chk("rst_val", 64'(o_rec_val), 0);
    chk_rec("rst_dat", o_rec_dat, '0);
    chk("rst_flags", {61'd0, o_busy, o_done, o_err}, 0);
    chk("rst_cnt", 64'(o_rec_cnt), 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    chk("rel_rdy_low", 64'(rx_if.rdy), 0);
    @(negedge i_clk);
    #1;
    chk("rel_rdy_high", 64'(rx_if.rdy), 1);
    @(negedge i_clk);

    // header table
    for (int i = 0; i < 7; i++) begin
      do_reset();
      d0 = n_done;
      hdr(tbl[i].op, tbl[i].n, tbl[i].eop, tbl[i].junk);
      repeat (3) @(negedge i_clk);
      #2;
      chk($sformatf("hdr%0d_err", i), 64'(o_err), 64'(tbl[i].exp_err));
      chk($sformatf("hdr%0d_done", i), 64'(n_done - d0), 64'(tbl[i].exp_done));
      chk($sformatf("hdr%0d_busy", i), 64'(o_busy), 64'(tbl[i].exp_busy));
      chk($sformatf("hdr%0d_val", i), 64'(o_rec_val), 0);
    end

    // N=5, all ready
    do_reset();
    d0 = n_done; l0 = log_core.size(); r0 = rdy_low;
    hdr(8'h01, 32'd5, 1'b0, '0);
    data_beats(1, 15, 15);
    repeat (6) @(negedge i_clk);
    chk_recs("n5", l0, 5, 1);
    chk("n5_nrec", 64'(log_core.size() - l0), 5);
    chk("n5_done", 64'(n_done - d0), 1);
    chk("n5_cnt", 64'(o_rec_cnt), 5);
    chk("n5_err", 64'(o_err), 0);
    chk("n5_busy", 64'(o_busy), 0);
    chk("n5_no_stall", 64'(rdy_low - r0), 0);

    // same packet with core 1 stalled for 20 cycles
    do_reset();
    d0 = n_done; l0 = log_core.size(); r0 = rdy_low;
    i_rec_rdy = 4'b1101;
    fork
      begin
        repeat (20) @(negedge i_clk);
        i_rec_rdy[1] = 1'b1;
      end
    join_none
    hdr(8'h01, 32'd5, 1'b0, '0);
    data_beats(2, 15, 15);
    repeat (6) @(negedge i_clk);
    chk_recs("stall", l0, 5, 2);
    chk("stall_nrec", 64'(log_core.size() - l0), 5);
    chk("stall_rdy_dropped", 64'(rdy_low - r0 > 0), 1);
    chk("stall_done", 64'(n_done - d0), 1);
    chk("stall_cnt", 64'(o_rec_cnt), 5);
    chk("stall_err", 64'(o_err), 0);

    // bad opcode: drained through eop
    do_reset();
    l0 = log_core.size();
    hdr(8'h07, 32'd1, 1'b0, '0);
    chk("badop_busy_drain", 64'(o_busy), 1);
    data_beats(3, 4, 4);
    repeat (3) @(negedge i_clk);
    #2;
    chk("badop_err", 64'(o_err), 1);
    chk("badop_nrec", 64'(log_core.size() - l0), 0);
    chk("badop_busy", 64'(o_busy), 0);
    chk("badop_rdy", 64'(rx_if.rdy), 1);
    @(negedge i_clk);

    // early eop on beat 5 of N=3
    do_reset();
    d0 = n_done; l0 = log_core.size();
    hdr(8'h01, 32'd3, 1'b0, '0);
    data_beats(4, 5, 5);
    repeat (4) @(negedge i_clk);
    chk("early_err", 64'(o_err), 1);
    chk("early_nrec", 64'(log_core.size() - l0), 1);
    chk_recs("early", l0, 1, 4);
    chk("early_done", 64'(n_done - d0), 0);
    chk("early_busy", 64'(o_busy), 0);
    chk("early_cnt", 64'(o_rec_cnt), 1);

    // N=0 packet then N=1
    do_reset();
    d0 = n_done; l0 = log_core.size();
    hdr(8'h01, 32'd0, 1'b1, '0);
    #2;
    chk("zero_done_pulse", 64'(o_done), 1);
    @(negedge i_clk);
    #2;
    chk("zero_done_once", 64'(o_done), 0);
    @(negedge i_clk);
    hdr(8'h01, 32'd1, 1'b0, '0);
    data_beats(5, 3, 3);
    repeat (4) @(negedge i_clk);
    chk("n1_done", 64'(n_done - d0), 2);
    chk("n1_nrec", 64'(log_core.size() - l0), 1);
    chk_recs("n1", l0, 1, 5);
    chk("n1_cnt", 64'(o_rec_cnt), 1);
    chk("n1_err", 64'(o_err), 0);

    // asynchronous reset mid-packet, then a fresh packet from core 0
    do_reset();
    l0 = log_core.size();
    hdr(8'h01, 32'd4, 1'b0, '0);
    data_beats(6, 4, 0);
    chk("mid_cnt_before", 64'(o_rec_cnt), 1);
    chk("mid_busy_before", 64'(o_busy), 1);
    #3;
    i_rst = 1'b1;
    #1;
    chk("mid_val", 64'(o_rec_val), 0);
    chk_rec("mid_dat", o_rec_dat, '0);
    chk("mid_cnt", 64'(o_rec_cnt), 0);
    chk("mid_flags", {61'd0, o_busy, o_done, o_err}, 0);
    chk("mid_rdy", 64'(rx_if.rdy), 0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    d0 = n_done; l0 = log_core.size();
    hdr(8'h01, 32'd2, 1'b0, '0);
    data_beats(7, 6, 6);
    repeat (4) @(negedge i_clk);
    chk_recs("fresh", l0, 2, 7);
    chk("fresh_done", 64'(n_done - d0), 1);
    chk("fresh_cnt", 64'(o_rec_cnt), 2);
    chk("fresh_err", 64'(o_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
